// File: rtl/sign_extend_2_if.sv
// sign_extend_2_if: immediate, control and result signals of the immediate extender
interface sign_extend_2_if #(
    parameter int IN_W  = 4,
    parameter int OUT_W = 16
);
    logic [IN_W-1:0]  in_buf;
    logic             ext_mode;
    logic [1:0]       scale;
    logic             valid_in;
    logic             stall;
    logic [OUT_W-1:0] out_m8;
    logic [OUT_W-1:0] out_m8_q;
    logic             valid_out;

    modport master (
        output in_buf, ext_mode, scale, valid_in, stall,
        input  out_m8, out_m8_q, valid_out
    );

    modport slave (
        input  in_buf, ext_mode, scale, valid_in, stall,
        output out_m8, out_m8_q, valid_out
    );
endinterface

// File: rtl/sign_extend_2.sv
// sign_extend_2: widens an immediate (zero/sign extension plus left scale) with a registered, valid-qualified copy
module sign_extend_2 #(
    parameter int IN_W      = 4,
    parameter int OUT_W     = 16,
    parameter int MAX_SHIFT = 3
) (
    input logic           clk,
    input logic           rst_n,
    sign_extend_2_if.slave bus
);
    logic             fill;
    logic [1:0]       shamt;
    logic [OUT_W-1:0] ext;
    logic [OUT_W-1:0] res;
    logic [OUT_W-1:0] res_q;
    logic             vld_q;

    // extend with zero or the immediate's msb, then scale by the clamped shift amount
    always_comb begin
        fill  = bus.ext_mode & bus.in_buf[IN_W-1];
        shamt = (int'(bus.scale) > MAX_SHIFT) ? 2'(MAX_SHIFT) : bus.scale;
        ext   = {{(OUT_W-IN_W){fill}}, bus.in_buf};
        res   = ext << shamt;
    end

    // pipeline copy: captured every unstalled edge regardless of valid_in, frozen while stalled
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_q <= '0;
            vld_q <= 1'b0;
        end else if (!bus.stall) begin
            res_q <= res;
            vld_q <= bus.valid_in;
        end
    end

    assign bus.out_m8    = res;
    assign bus.out_m8_q  = res_q;
    assign bus.valid_out = vld_q;
endmodule

// File: tb/tb_sign_extend_2.sv
// tb_sign_extend_2: table-driven and scoreboarded checks of the immediate extender
module tb_sign_extend_2;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [3:0]  b;
        logic        m;
        logic [1:0]  s;
        logic [15:0] e;
    } vec_t;

    typedef struct {
        logic [15:0] q;
        logic        v;
    } exp_t;

    vec_t tbl [12];
    exp_t sb [$];
    exp_t cur;

    sign_extend_2_if #(.IN_W(4), .OUT_W(16)) bus_if ();

    sign_extend_2 #(.IN_W(4), .OUT_W(16), .MAX_SHIFT(3)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus_if)
    );

    always #10 clk = ~clk;

    function automatic logic [15:0] model(input logic [3:0] b, input logic m, input logic [1:0] s);
        int v;
        int sh;
        v  = (m && b >= 4'd8) ? int'(b) - 16 : int'(b);
        sh = (int'(s) > 3) ? 3 : int'(s);
        v  = v * (1 << sh);
        return 16'(v);
    endfunction

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [3:0] b, input logic m, input logic [1:0] s, input logic v, input logic st);
        bus_if.in_buf   = b;
        bus_if.ext_mode = m;
        bus_if.scale    = s;
        bus_if.valid_in = v;
        bus_if.stall    = st;
    endtask

    task automatic step(input logic [3:0] b, input logic m, input logic [1:0] s, input logic v, input logic st);
        exp_t e;
        @(negedge clk);
        drive(b, m, s, v, st);
        #1;
        chk("comb", bus_if.out_m8, model(b, m, s));
        if (!st) begin
            e.q = model(b, m, s);
            e.v = v;
            sb.push_back(e);
        end
        @(posedge clk);
        #1;
        if (!st) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL scoreboard empty");
            end else begin
                cur = sb.pop_front();
            end
        end
        chk("out_m8_q", bus_if.out_m8_q, cur.q);
        chk("valid_out", 16'(bus_if.valid_out), 16'(cur.v));
    endtask

    initial begin
        tbl[0]  = '{4'b0101, 1'b0, 2'd0, 16'h0005};
        tbl[1]  = '{4'b1011, 1'b0, 2'd0, 16'h000B};
        tbl[2]  = '{4'b0001, 1'b0, 2'd0, 16'h0001};
        tbl[3]  = '{4'b0000, 1'b0, 2'd0, 16'h0000};
        tbl[4]  = '{4'b1111, 1'b0, 2'd0, 16'h000F};
        tbl[5]  = '{4'b1011, 1'b1, 2'd0, 16'hFFFB};
        tbl[6]  = '{4'b0111, 1'b1, 2'd0, 16'h0007};
        tbl[7]  = '{4'b1000, 1'b1, 2'd0, 16'hFFF8};
        tbl[8]  = '{4'b1111, 1'b1, 2'd1, 16'hFFFE};
        tbl[9]  = '{4'b1111, 1'b0, 2'd3, 16'h0078};
        tbl[10] = '{4'b1000, 1'b1, 2'd3, 16'hFFC0};
        tbl[11] = '{4'b0111, 1'b1, 2'd2, 16'h001C};
        cur.q = '0;
        cur.v = 1'b0;
        drive(4'b0000, 1'b0, 2'd0, 1'b1, 1'b0);

        // combinational table, applied while held in reset
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            drive(tbl[i].b, tbl[i].m, tbl[i].s, 1'b1, 1'b0);
            #1;
            chk($sformatf("tbl%0d", i), bus_if.out_m8, tbl[i].e);
            chk("rst_q", bus_if.out_m8_q, 16'h0000);
            chk("rst_v", 16'(bus_if.valid_out), 16'h0000);
        end

        // release reset between edges, then load 0x0005
        @(posedge clk);
        #1 rst_n = 1'b1;
        step(4'b0101, 1'b0, 2'd0, 1'b1, 1'b0);
        chk("load5", bus_if.out_m8_q, 16'h0005);

        // stall for 3 edges with new data and valid_in dropped: register holds
        for (int i = 0; i < 3; i++) step(4'b1011, 1'b0, 2'd0, 1'b0, 1'b1);
        chk("stall_hold", bus_if.out_m8_q, 16'h0005);
        step(4'b1011, 1'b0, 2'd0, 1'b1, 1'b0);
        chk("unstall", bus_if.out_m8_q, 16'h000B);

        // asynchronous reset pulse between edges
        #4 rst_n = 1'b0;
        #1;
        chk("async_q", bus_if.out_m8_q, 16'h0000);
        chk("async_v", 16'(bus_if.valid_out), 16'h0000);
        chk("async_comb", bus_if.out_m8, 16'h000B);
        sb.delete();
        cur.q = '0;
        cur.v = 1'b0;
        @(posedge clk);
        #1;
        chk("rst_hold_q", bus_if.out_m8_q, 16'h0000);
        rst_n = 1'b1;

        // random traffic with random stalls
        for (int i = 0; i < 60; i++)
            step(4'($urandom), 1'($urandom), 2'($urandom), 1'($urandom), ($urandom_range(0, 3) == 0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
